// File: rtl/iq_pkg.sv
// ============================================================================
//  Module      : iq_pkg
//  Description : Shared widths, instruction field layout and word type for the
//                instruction prefetch queue and its field decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package iq_pkg;

    localparam int DEF_INSTR_W = 16;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_OP_W    = 4;
    localparam int DEF_REG_W   = 3;
    localparam int DEF_FUNCT_W = 3;
    localparam int DEF_IIMM_W  = 6;
    localparam int DEF_JIMM_W  = DEF_INSTR_W - DEF_OP_W;
    localparam int DEF_DATA_W  = 16;

    // Field layout for the default widths, MSB first: op | rd | rs | rt | funct
    localparam int OP_HI    = DEF_INSTR_W - 1;
    localparam int OP_LO    = DEF_INSTR_W - DEF_OP_W;
    localparam int RD_HI    = OP_LO - 1;
    localparam int RD_LO    = RD_HI - DEF_REG_W + 1;
    localparam int RS_HI    = RD_LO - 1;
    localparam int RS_LO    = RS_HI - DEF_REG_W + 1;
    localparam int RT_HI    = RS_LO - 1;
    localparam int RT_LO    = RT_HI - DEF_REG_W + 1;
    localparam int FUNCT_HI = DEF_FUNCT_W - 1;
    localparam int FUNCT_LO = 0;
    localparam int IIMM_HI  = DEF_IIMM_W - 1;
    localparam int JIMM_HI  = DEF_JIMM_W - 1;

    typedef logic [DEF_INSTR_W-1:0] instr_t;

endpackage

`default_nettype wire

// File: rtl/instr_field_decode.sv
// ============================================================================
//  Module      : instr_field_decode
//  Description : Purely combinational slicing of an instruction word into its
//                fields, with a sign-extended I-immediate. Shared with control.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_field_decode
    import iq_pkg::*;
#(
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int OP_W    = DEF_OP_W,
    parameter int REG_W   = DEF_REG_W,
    parameter int FUNCT_W = DEF_FUNCT_W,
    parameter int IIMM_W  = DEF_IIMM_W,
    parameter int JIMM_W  = INSTR_W - OP_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic [INSTR_W-1:0] word,
    output logic [OP_W-1:0]    op,
    output logic [REG_W-1:0]   rd,
    output logic [REG_W-1:0]   rs,
    output logic [REG_W-1:0]   rt,
    output logic [FUNCT_W-1:0] funct,
    output logic [DATA_W-1:0]  i_imm,
    output logic [JIMM_W-1:0]  j_imm
);

    localparam int c_op_lo = INSTR_W - OP_W;
    localparam int c_rd_hi = c_op_lo - 1;
    localparam int c_rd_lo = c_rd_hi - REG_W + 1;
    localparam int c_rs_hi = c_rd_lo - 1;
    localparam int c_rs_lo = c_rs_hi - REG_W + 1;
    localparam int c_rt_hi = c_rs_lo - 1;
    localparam int c_rt_lo = c_rt_hi - REG_W + 1;

    assign op    = word[INSTR_W-1:c_op_lo];
    assign rd    = word[c_rd_hi:c_rd_lo];
    assign rs    = word[c_rs_hi:c_rs_lo];
    assign rt    = word[c_rt_hi:c_rt_lo];
    assign funct = word[FUNCT_W-1:0];
    assign j_imm = word[JIMM_W-1:0];

    // A zero-width replication is illegal, so the no-extension case is split out
    generate
        if (DATA_W > IIMM_W) begin : g_sext
            assign i_imm = {{(DATA_W-IIMM_W){word[IIMM_W-1]}}, word[IIMM_W-1:0]};
        end else begin : g_nosext
            assign i_imm = word[IIMM_W-1:0];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/instr_queue_decode.sv
// ============================================================================
//  Module      : instr_queue_decode
//  Description : DEPTH-entry instruction prefetch queue with valid/ready on
//                both sides; the head entry is decoded into instruction fields.
//                Optional macro IQ_HOLD_LAST_EN keeps the last popped word
//                decoded while the queue is empty.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_queue_decode
    import iq_pkg::*;
#(
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int OP_W    = DEF_OP_W,
    parameter int REG_W   = DEF_REG_W,
    parameter int FUNCT_W = DEF_FUNCT_W,
    parameter int IIMM_W  = DEF_IIMM_W,
    parameter int JIMM_W  = INSTR_W - OP_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [INSTR_W-1:0]         in_instr,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OP_W-1:0]            op,
    output logic [REG_W-1:0]           rd,
    output logic [REG_W-1:0]           rs,
    output logic [REG_W-1:0]           rt,
    output logic [FUNCT_W-1:0]         funct,
    output logic [DATA_W-1:0]          i_imm,
    output logic [JIMM_W-1:0]          j_imm,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [INSTR_W-1:0] r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic               w_push;
    logic               w_pop;
    logic [INSTR_W-1:0] w_head;
    logic [INSTR_W-1:0] w_dec_word;

    assign in_ready  = (r_count != c_cnt_w'(DEPTH));
    assign out_valid = (r_count != '0);
    assign count     = r_count;

    // flush wins: neither side of the handshake takes effect in a flush cycle
    assign w_push = in_valid && in_ready && !flush;
    assign w_pop  = out_valid && out_ready && !flush;
    assign w_head = r_mem[r_rd_ptr];

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_instr;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_w'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_cnt_w'(1);
            end
        end
    end

`ifdef IQ_HOLD_LAST_EN
    // Mirrors the legacy latch: fields persist after the consumer takes the word
    logic [INSTR_W-1:0] r_last;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last <= '0;
        end else if (w_pop) begin
            r_last <= w_head;
        end
    end

    assign w_dec_word = out_valid ? w_head : r_last;
`else
    assign w_dec_word = out_valid ? w_head : '0;
`endif

    instr_field_decode #(
        .INSTR_W (INSTR_W),
        .OP_W    (OP_W),
        .REG_W   (REG_W),
        .FUNCT_W (FUNCT_W),
        .IIMM_W  (IIMM_W),
        .JIMM_W  (JIMM_W),
        .DATA_W  (DATA_W)
    ) u_decode (
        .word  (w_dec_word),
        .op    (op),
        .rd    (rd),
        .rs    (rs),
        .rt    (rt),
        .funct (funct),
        .i_imm (i_imm),
        .j_imm (j_imm)
    );

endmodule

`default_nettype wire

// File: tb/tb_instr_queue_decode.sv
// ============================================================================
//  Module      : tb_instr_queue_decode
//  Description : Directed self-checking bench for instr_queue_decode.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_queue_decode;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  funct;
    logic [15:0] i_imm;
    logic [11:0] j_imm;
    logic [2:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    instr_queue_decode dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op        (op),
        .rd        (rd),
        .rs        (rs),
        .rt        (rt),
        .funct     (funct),
        .i_imm     (i_imm),
        .j_imm     (j_imm),
        .count     (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [15:0] fill_words [5];
    logic [15:0] model [$];
    logic [15:0] w;

    initial begin
        fill_words[0] = 16'h1111; fill_words[1] = 16'h2222; fill_words[2] = 16'h3333;
        fill_words[3] = 16'h4444; fill_words[4] = 16'h5555;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
        tick(); tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_count",     {29'd0, count},     32'd0);
        check("rst_fields",    {op, rd, rs, rt, funct, i_imm}, 32'd0);
        reset = 1'b0;
        tick();

        // Single push: latency one, then decoded head
        in_valid = 1'b1; in_instr = 16'h1A4B;
        tick();
        in_valid = 1'b0;
        check("p1_out_valid", {31'd0, out_valid}, 32'd1);
        check("p1_op",    {28'd0, op},    32'd1);
        check("p1_rd",    {29'd0, rd},    32'd5);
        check("p1_rs",    {29'd0, rs},    32'd1);
        check("p1_rt",    {29'd0, rt},    32'd1);
        check("p1_funct", {29'd0, funct}, 32'd3);
        check("p1_i_imm", {16'd0, i_imm}, 32'h000B);
        check("p1_j_imm", {20'd0, j_imm}, 32'hA4B);
        check("p1_count", {29'd0, count}, 32'd1);

        // Push 2E3F while popping 1A4B: head becomes 2E3F, count stays 1
        in_valid = 1'b1; in_instr = 16'h2E3F; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        check("p2_count", {29'd0, count}, 32'd1);
        check("p2_rd",    {29'd0, rd},    32'd7);
        check("p2_rs",    {29'd0, rs},    32'd0);
        check("p2_rt",    {29'd0, rt},    32'd7);
        check("p2_funct", {29'd0, funct}, 32'd7);
        check("p2_i_imm", {16'd0, i_imm}, 32'hFFFF);
        check("p2_j_imm", {20'd0, j_imm}, 32'hE3F);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("p2_empty", {31'd0, out_valid}, 32'd0);

        // Fill to DEPTH, fifth push refused
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_instr = fill_words[i];
            tick();
            if (i == 3) begin
                check("full_count",    {29'd0, count},    32'd4);
                check("full_in_ready", {31'd0, in_ready}, 32'd0);
            end
        end
        in_valid = 1'b0;
        check("full_after5", {29'd0, count}, 32'd4);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_%0d", i), {16'd0, op, j_imm}, {16'd0, fill_words[i]});
            tick();
        end
        out_ready = 1'b0;
        check("drain_count", {29'd0, count}, 32'd0);

        // Steady push+pop at count=2 across pointer wrap
        model.delete();
        for (int i = 0; i < 2; i++) begin
            w = 16'h100A + 16'(i) * 16'h1001;
            in_valid = 1'b1; in_instr = w; model.push_back(w);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            w = 16'h3000 + 16'(i) * 16'h0111;
            in_valid = 1'b1; in_instr = w; out_ready = 1'b1;
            check($sformatf("wrap_head_%0d", i), {16'd0, op, j_imm}, {16'd0, model[0]});
            void'(model.pop_front());
            model.push_back(w);
            tick();
            check($sformatf("wrap_count_%0d", i), {29'd0, count}, 32'd2);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("wrap_tail_%0d", i), {16'd0, op, j_imm}, {16'd0, model[0]});
            void'(model.pop_front());
            tick();
        end
        out_ready = 1'b0;
        check("wrap_empty", {29'd0, count}, 32'd0);

        // Flush at count=3 with a simultaneous push
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_instr = 16'hA001 + 16'(i);
            tick();
        end
        check("pre_flush_count", {29'd0, count}, 32'd3);
        flush = 1'b1; in_valid = 1'b1; in_instr = 16'hBEEF;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_count",     {29'd0, count},     32'd0);
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_in_ready",  {31'd0, in_ready},  32'd1);
        tick();
        check("flush_dropped", {29'd0, count}, 32'd0);

        // Pop the last entry and inspect the empty-queue fields
        in_valid = 1'b1; in_instr = 16'hC123;
        tick();
        in_valid = 1'b0;
        check("c123_head", {16'd0, op, j_imm}, 32'hC123);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("last_out_valid", {31'd0, out_valid}, 32'd0);
`ifdef IQ_HOLD_LAST_EN
        check("hold_op",    {28'd0, op},    32'hC);
        check("hold_rs",    {29'd0, rs},    32'd4);
        check("hold_i_imm", {16'd0, i_imm}, 32'hFFE3);
        check("hold_j_imm", {20'd0, j_imm}, 32'h123);
`else
        check("zero_op",    {28'd0, op},    32'd0);
        check("zero_rs",    {29'd0, rs},    32'd0);
        check("zero_i_imm", {16'd0, i_imm}, 32'd0);
        check("zero_j_imm", {20'd0, j_imm}, 32'd0);
`endif

        // Asynchronous reset mid-stream, between clock edges
        in_valid = 1'b1; in_instr = 16'h5A5A;
        tick();
        in_instr = 16'h6B6B;
        tick();
        in_valid = 1'b0;
        check("pre_rst_count", {29'd0, count}, 32'd2);
        #1;
        reset = 1'b1;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_count",     {29'd0, count},     32'd0);
        check("arst_in_ready",  {31'd0, in_ready},  32'd1);
        check("arst_fields",    {op, j_imm, rd, rs, rt, funct}, 32'd0);
        check("arst_i_imm",     {16'd0, i_imm},     32'd0);
        tick();
        reset = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_queue_decode.md
Name: instr_queue_decode

Overview:
Parametrised successor to the single-entry instruction latch. It is a DEPTH-entry instruction prefetch queue with valid/ready handshakes on both sides. The head entry is decoded into op/rd/rs/rt/funct fields, plus a sign-extended I-immediate and a J-immediate. It sits between instruction memory fetch and the control FSM/register file, so fetch can run ahead of execute.

Parameters:
INSTR_W, 16, instruction width in bits
DEPTH, 4, queue entries (power of two, >=2)
OP_W, 4, opcode width (MSBs of instruction)
REG_W, 3, width of each register specifier rd/rs/rt
FUNCT_W, 3, function field width (LSBs)
IIMM_W, 6, I-type immediate width (LSBs)
JIMM_W, 12, J-type immediate width (INSTR_W-OP_W LSBs)
DATA_W, 16, datapath width for the sign-extended immediate

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous discard of all queued entries (branch/jump redirect)
in_valid  in  1  fetch presents an instruction
in_instr  in  INSTR_W  fetched instruction word
in_ready  out  1  queue can accept; equals (count != DEPTH)
out_valid  out  1  head entry valid; equals (count != 0)
out_ready  in  1  consumer accepts head (IRWrite equivalent)
op  out  OP_W  in_instr[15:12] of head
rd  out  REG_W  [11:9] of head
rs  out  REG_W  [8:6] of head
rt  out  REG_W  [5:3] of head
funct  out  FUNCT_W  [2:0] of head
i_imm  out  DATA_W  [5:0] of head, sign-extended from bit IIMM_W-1
j_imm  out  JIMM_W  [11:0] of head, unextended
count  out  $clog2(DEPTH)+1  number of occupied entries

Behaviour:
- Reset (async, active-high) clears count, rd_ptr and wr_ptr to 0. Consequently out_valid=0, in_ready=1, and all field outputs are 0. Storage contents are don't-care.
- Push occurs when in_valid && in_ready. The entry is written at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop occurs when out_valid && out_ready; rd_ptr increments modulo DEPTH.
- Push and pop in the same cycle leave count unchanged. This is legal at count=1..DEPTH-1. At count=DEPTH, in_ready=0, so only the pop happens. At count=0, out_valid=0, so only the push happens.
- There is no fall-through path. An instruction pushed into an empty queue is visible at out_valid/fields on the cycle after the push edge (latency 1).
- in_ready depends only on count, not on out_ready. There is no combinational in->out path.
- Field outputs are combinational slices of the storage entry at rd_ptr.
- Widths derive from the parameters. op is the top OP_W bits. J-field is the low INSTR_W-OP_W bits.
- i_imm: the low IIMM_W bits are replicated-MSB extended to DATA_W. DATA_W >= IIMM_W is required.
- flush has priority over push and pop. At the next edge, count, rd_ptr and wr_ptr become 0, and any push in the same cycle is dropped.
- Pointer wrap: after DEPTH pushes and DEPTH pops, both pointers return to 0. Wrap must not corrupt ordering.
- When out_valid=0, field outputs are 0 (see Optional Feature).
- Reset asserted mid-stream immediately deasserts out_valid and drops all entries.

Optional Feature:
Macro IQ_HOLD_LAST_EN.
- Defined: an extra INSTR_W register captures the head word on every pop. This register is cleared by reset, not by flush. While out_valid=0, the field outputs decode this held word, matching legacy latch semantics where fields persist after IRWrite.
- Undefined: fields are forced to 0 whenever out_valid=0, and no extra register exists.

Decomposition:
- Shared package iq_pkg:
  - field position localparams (OP_HI/LO, RD_HI/LO, RS_HI/LO, RT_HI/LO, FUNCT_HI/LO, IIMM_HI, JIMM_HI)
  - default widths
  - an instr_t typedef of INSTR_W bits
- One combinational sub-module, instr_field_decode: word in; op/rd/rs/rt/funct/i_imm/j_imm out. It is reused by the control unit.
- The queue top holds storage, pointers, count and handshakes.

Test Plan:
- Reset then push 16'h1A4B; next cycle expect out_valid=1, op=1, rd=5, rs=1, rt=1, funct=3, i_imm=16'h000B, j_imm=12'hA4B, count=1.
- Push 16'h2E3F -> expect rd=7, rs=0, rt=7, funct=7, i_imm=16'hFFFF, j_imm=12'hE3F.
- Push 4 words with out_ready=0 -> expect count=4, in_ready=0. Fifth push is ignored. Then pop all 4 and check FIFO order, then expect count=0.
- Hold count=2 and push+pop every cycle for 10 cycles (forces pointer wrap) -> expect count stays 2 and outputs appear in exact push order.
- Use count=3 and assert flush together with in_valid -> next cycle expect count=0, out_valid=0, and the pushed word discarded.
- Pop the last entry: with IQ_HOLD_LAST_EN, fields keep the last popped word; without it, all fields read 0. Then assert reset mid-stream -> all outputs go to 0 asynchronously.
